// File: rtl/fetch_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fetch_sequencer                                               |
// | Brief    : Instruction fetch front end. Issues single-outstanding word   |
// |            reads and queues {pc,instr} pairs for execute. Optional macro |
// |            FETCH_TIMEOUT_EN adds a read wait timeout.                    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module fetch_sequencer #(
  parameter int unsigned     XLEN           = 32,
  parameter int unsigned     DEPTH          = 4,
  parameter logic [XLEN-1:0] RESET_PC       = 'h800,
  parameter logic [3:0]      CMD_NOP        = 4'h0,
  parameter logic [3:0]      CMD_READ       = 4'h1,
  parameter int unsigned     TIMEOUT_CYCLES = 255
) (
  input  logic            clock,
  input  logic            reset,
  output logic [3:0]      mem_cmd,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_ready,
  input  logic            mem_error,
  input  logic [31:0]     mem_rdata,
  input  logic            fetch_hold,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            issue_valid,
  input  logic            issue_ready,
  output logic [XLEN-1:0] issue_pc,
  output logic [31:0]     issue_instr,
  output logic            trap_valid,
  output logic [1:0]      trap_cause,
  output logic [XLEN-1:0] trap_pc
);

  localparam int unsigned c_AW = $clog2(DEPTH);
  localparam int unsigned c_CW = c_AW + 1;
  localparam logic [c_CW-1:0] c_DEPTH = c_CW'(DEPTH);

  localparam logic [2:0] c_INIT  = 3'd0;
  localparam logic [2:0] c_IDLE  = 3'd1;
  localparam logic [2:0] c_WAIT  = 3'd2;
  localparam logic [2:0] c_DRAIN = 3'd3;
  localparam logic [2:0] c_TRAP  = 3'd4;

  logic [2:0]      r_state;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_fifo_pc    [DEPTH];
  logic [31:0]     r_fifo_instr [DEPTH];
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_CW-1:0] r_count;

  logic [2:0]      w_state_next;
  logic [XLEN-1:0] w_fetch_pc_next;
  logic [XLEN-1:0] w_addr_next;
  logic [c_CW-1:0] w_count_pushed;
  logic            w_push;
  logic            w_pop;
  logic            w_flush;
  logic            w_trap_set;
  logic [1:0]      w_trap_cause;
  logic            w_timeout;

  assign issue_valid = (r_count != '0);
  assign issue_pc    = r_fifo_pc[r_rd_ptr];
  assign issue_instr = r_fifo_instr[r_rd_ptr];
  assign w_pop       = issue_valid & issue_ready;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned c_TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [c_TW-1:0] r_wait_cnt;

  assign w_timeout = !mem_ready && (r_wait_cnt == c_TW'(TIMEOUT_CYCLES - 1));

  // Restarts whenever a read is launched or the state changes.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wait_cnt <= '0;
    end else if (w_state_next != r_state || mem_ready) begin
      r_wait_cnt <= '0;
    end else if (r_state == c_WAIT || r_state == c_DRAIN) begin
      r_wait_cnt <= r_wait_cnt + c_TW'(1);
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_next    = r_state;
    w_fetch_pc_next = r_fetch_pc;
    w_addr_next     = mem_addr;
    w_push          = 1'b0;
    w_flush         = 1'b0;
    w_trap_set      = 1'b0;
    w_trap_cause    = 2'd0;
    w_count_pushed  = r_count + c_CW'(1) - c_CW'(w_pop);
    case (r_state)
      c_INIT: begin
        w_fetch_pc_next = RESET_PC;
        w_state_next    = c_IDLE;
      end
      c_IDLE: begin
        if (!fetch_hold && r_count < c_DEPTH) begin
          w_addr_next  = r_fetch_pc;
          w_state_next = c_WAIT;
        end
      end
      c_WAIT: begin
        if (mem_ready && mem_error) begin
          w_trap_set   = 1'b1;
          w_trap_cause = 2'd1;
          w_state_next = c_TRAP;
        end else if (mem_ready) begin
          w_push          = 1'b1;
          w_fetch_pc_next = r_fetch_pc + XLEN'(4);
          if (w_count_pushed < c_DEPTH && !fetch_hold) begin
            w_addr_next = r_fetch_pc + XLEN'(4);
          end else begin
            w_state_next = c_IDLE;
          end
        end else if (w_timeout) begin
          w_trap_set   = 1'b1;
          w_trap_cause = 2'd2;
          w_state_next = c_TRAP;
        end
      end
      c_DRAIN: begin
        if (mem_ready || w_timeout) begin
          w_state_next = c_IDLE;
        end
      end
      c_TRAP: begin
        w_state_next = c_TRAP;
      end
      default: begin
        w_state_next = c_INIT;
      end
    endcase

    // Redirect overrides everything; an unfinished read must still be drained.
    if (redirect_valid && r_state != c_INIT) begin
      w_flush         = 1'b1;
      w_push          = 1'b0;
      w_trap_set      = 1'b0;
      w_fetch_pc_next = redirect_pc;
      w_addr_next     = mem_addr;
      if ((r_state == c_WAIT || r_state == c_DRAIN) && !mem_ready) begin
        w_state_next = c_DRAIN;
      end else begin
        w_state_next = c_IDLE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= c_INIT;
      r_fetch_pc <= '0;
      mem_cmd    <= CMD_NOP;
      mem_addr   <= '0;
      trap_valid <= 1'b0;
      trap_cause <= 2'd0;
      trap_pc    <= '0;
    end else begin
      r_state    <= w_state_next;
      r_fetch_pc <= w_fetch_pc_next;
      mem_addr   <= w_addr_next;
      mem_cmd    <= (w_state_next == c_WAIT || w_state_next == c_DRAIN) ? CMD_READ : CMD_NOP;
      if (w_flush) begin
        trap_valid <= 1'b0;
        trap_cause <= 2'd0;
        trap_pc    <= '0;
      end else if (w_trap_set) begin
        trap_valid <= 1'b1;
        trap_cause <= w_trap_cause;
        trap_pc    <= mem_addr;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fifo_pc[r_wr_ptr]    <= mem_addr;
        r_fifo_instr[r_wr_ptr] <= mem_rdata;
        r_wr_ptr               <= r_wr_ptr + c_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_AW'(1);
      end
      r_count <= r_count + c_CW'(w_push) - c_CW'(w_pop);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// Directed self-checking bench for fetch_sequencer (DEPTH=4, TIMEOUT_CYCLES=8).
module tb_fetch_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  mem_cmd;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic        mem_error;
  logic [31:0] mem_rdata;
  logic        fetch_hold;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        issue_valid;
  logic        issue_ready;
  logic [31:0] issue_pc;
  logic [31:0] issue_instr;
  logic        trap_valid;
  logic [1:0]  trap_cause;
  logic [31:0] trap_pc;

  int n_total = 0;
  int n_pass  = 0;

  localparam logic [31:0] c_KEY = 32'hA5A5_0000;

  fetch_sequencer #(
    .XLEN(32), .DEPTH(4), .RESET_PC(32'h800),
    .CMD_NOP(4'h0), .CMD_READ(4'h1), .TIMEOUT_CYCLES(8)
  ) dut (
    .clock(clock), .reset(reset),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_error(mem_error), .mem_rdata(mem_rdata),
    .fetch_hold(fetch_hold),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_pc(issue_pc), .issue_instr(issue_instr),
    .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc)
  );

  always #5 clock = ~clock;

  // Memory model: data word is derived from the address being read.
  assign mem_rdata = mem_addr ^ c_KEY;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Leaves the bench 1 time unit after the last edge that samples reset high.
  task automatic do_reset(input logic rdy, input logic irdy);
    reset = 1'b1; mem_ready = rdy; mem_error = 1'b0; fetch_hold = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; issue_ready = irdy;
    tick; tick;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset(1'b1, 1'b1);
    n_total++; if (mem_cmd !== 4'h0)    $display("FAIL rst_cmd got %h want 0", mem_cmd);      else n_pass++;
    n_total++; if (mem_addr !== 32'h0)  $display("FAIL rst_addr got %h want 0", mem_addr);    else n_pass++;
    n_total++; if (issue_valid !== 1'b0) $display("FAIL rst_issue_valid got %b want 0", issue_valid); else n_pass++;
    n_total++; if ({trap_valid, trap_cause, trap_pc} !== 35'h0)
      $display("FAIL rst_trap got v=%b c=%0d pc=%h want all 0", trap_valid, trap_cause, trap_pc); else n_pass++;
  endtask

  task automatic test_back_to_back;
    do_reset(1'b1, 1'b1);
    tick; // E+1: INIT done, IDLE
    n_total++; if (mem_cmd !== 4'h0) $display("FAIL b2b_e1_cmd got %h want 0", mem_cmd); else n_pass++;
    tick; // E+2: first read
    n_total++; if ({mem_cmd, mem_addr} !== {4'h1, 32'h800})
      $display("FAIL b2b_e2_read got cmd=%h addr=%h want 1/800", mem_cmd, mem_addr); else n_pass++;
    n_total++; if (issue_valid !== 1'b0) $display("FAIL b2b_e2_valid got %b want 0", issue_valid); else n_pass++;
    tick; // E+3
    n_total++; if ({issue_valid, issue_pc, issue_instr} !== {1'b1, 32'h800, 32'h800 ^ c_KEY})
      $display("FAIL b2b_e3_issue got v=%b pc=%h instr=%h want 1/800/%h", issue_valid, issue_pc, issue_instr, 32'h800 ^ c_KEY); else n_pass++;
    n_total++; if ({mem_cmd, mem_addr} !== {4'h1, 32'h804})
      $display("FAIL b2b_e3_read got cmd=%h addr=%h want 1/804", mem_cmd, mem_addr); else n_pass++;
    tick;
    n_total++; if ({issue_valid, issue_pc, mem_addr} !== {1'b1, 32'h804, 32'h808})
      $display("FAIL b2b_e4 got v=%b pc=%h addr=%h want 1/804/808", issue_valid, issue_pc, mem_addr); else n_pass++;
    tick;
    n_total++; if ({issue_pc, issue_instr} !== {32'h808, 32'h808 ^ c_KEY})
      $display("FAIL b2b_e5 got pc=%h instr=%h want 808/%h", issue_pc, issue_instr, 32'h808 ^ c_KEY); else n_pass++;
  endtask

  task automatic test_fifo_full;
    int reads;
    do_reset(1'b1, 1'b0);
    reads = 0;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (mem_cmd == 4'h1) reads++;
    end
    n_total++; if (reads !== 4) $display("FAIL full_reads got %0d want 4", reads); else n_pass++;
    n_total++; if ({mem_cmd, issue_valid, issue_pc} !== {4'h0, 1'b1, 32'h800})
      $display("FAIL full_hold got cmd=%h v=%b pc=%h want 0/1/800", mem_cmd, issue_valid, issue_pc); else n_pass++;
    issue_ready = 1'b1;
    tick;
    issue_ready = 1'b0;
    n_total++; if ({mem_cmd, issue_pc} !== {4'h0, 32'h804})
      $display("FAIL full_pop got cmd=%h pc=%h want 0/804", mem_cmd, issue_pc); else n_pass++;
    tick;
    n_total++; if ({mem_cmd, mem_addr} !== {4'h1, 32'h810})
      $display("FAIL full_refill got cmd=%h addr=%h want 1/810", mem_cmd, mem_addr); else n_pass++;
    tick;
    n_total++; if (mem_cmd !== 4'h0) $display("FAIL full_refull_cmd got %h want 0", mem_cmd); else n_pass++;
  endtask

  task automatic test_redirect_drain;
    do_reset(1'b0, 1'b1);
    tick; tick; tick; // read 0x800 outstanding
    redirect_valid = 1'b1; redirect_pc = 32'h2000;
    tick;
    redirect_valid = 1'b0;
    n_total++; if ({mem_cmd, mem_addr} !== {4'h1, 32'h800})
      $display("FAIL rdr_drain got cmd=%h addr=%h want 1/800", mem_cmd, mem_addr); else n_pass++;
    tick; tick;
    mem_ready = 1'b1;
    tick;
    n_total++; if ({mem_cmd, issue_valid} !== {4'h0, 1'b0})
      $display("FAIL rdr_done got cmd=%h v=%b want 0/0", mem_cmd, issue_valid); else n_pass++;
    tick;
    n_total++; if ({mem_cmd, mem_addr, issue_valid} !== {4'h1, 32'h2000, 1'b0})
      $display("FAIL rdr_new got cmd=%h addr=%h v=%b want 1/2000/0", mem_cmd, mem_addr, issue_valid); else n_pass++;
    tick;
    n_total++; if ({issue_valid, issue_pc} !== {1'b1, 32'h2000})
      $display("FAIL rdr_issue got v=%b pc=%h want 1/2000", issue_valid, issue_pc); else n_pass++;
  endtask

  task automatic test_bus_error;
    do_reset(1'b1, 1'b0);
    tick; tick; tick; // 0x800 pushed, 0x804 outstanding
    mem_error = 1'b1;
    tick;
    mem_error = 1'b0;
    n_total++; if ({trap_valid, trap_cause, trap_pc} !== {1'b1, 2'd1, 32'h804})
      $display("FAIL err_trap got v=%b c=%0d pc=%h want 1/1/804", trap_valid, trap_cause, trap_pc); else n_pass++;
    tick; tick;
    n_total++; if ({mem_cmd, issue_valid, issue_pc} !== {4'h0, 1'b1, 32'h800})
      $display("FAIL err_hold got cmd=%h v=%b pc=%h want 0/1/800", mem_cmd, issue_valid, issue_pc); else n_pass++;
    issue_ready = 1'b1;
    tick;
    n_total++; if ({issue_valid, trap_valid} !== 2'b01)
      $display("FAIL err_drained got v=%b trap=%b want 0/1", issue_valid, trap_valid); else n_pass++;
    redirect_valid = 1'b1; redirect_pc = 32'h3000;
    tick;
    redirect_valid = 1'b0;
    n_total++; if ({trap_valid, trap_cause} !== 3'b0)
      $display("FAIL err_clear got v=%b c=%0d want 0/0", trap_valid, trap_cause); else n_pass++;
    tick;
    n_total++; if ({mem_cmd, mem_addr} !== {4'h1, 32'h3000})
      $display("FAIL err_restart got cmd=%h addr=%h want 1/3000", mem_cmd, mem_addr); else n_pass++;
  endtask

  task automatic test_timeout;
    do_reset(1'b0, 1'b1);
    tick; tick; // E+2: read 0x800 begins
`ifdef FETCH_TIMEOUT_EN
    for (int i = 0; i < 7; i++) tick;
    n_total++; if ({mem_cmd, trap_valid} !== {4'h1, 1'b0})
      $display("FAIL to_early got cmd=%h trap=%b want 1/0", mem_cmd, trap_valid); else n_pass++;
    tick;
    n_total++; if ({mem_cmd, trap_valid, trap_cause, trap_pc} !== {4'h0, 1'b1, 2'd2, 32'h800})
      $display("FAIL to_trap got cmd=%h v=%b c=%0d pc=%h want 0/1/2/800", mem_cmd, trap_valid, trap_cause, trap_pc); else n_pass++;
`else
    for (int i = 0; i < 20; i++) tick;
    n_total++; if ({mem_cmd, mem_addr, trap_valid, trap_cause} !== {4'h1, 32'h800, 1'b0, 2'd0})
      $display("FAIL to_wait got cmd=%h addr=%h v=%b c=%0d want 1/800/0/0", mem_cmd, mem_addr, trap_valid, trap_cause); else n_pass++;
`endif
  endtask

  task automatic test_hold;
    do_reset(1'b1, 1'b1);
    tick; tick; // E+2: read 0x800
    fetch_hold = 1'b1;
    tick;
    n_total++; if ({mem_cmd, issue_valid, issue_pc} !== {4'h0, 1'b1, 32'h800})
      $display("FAIL hold_stop got cmd=%h v=%b pc=%h want 0/1/800", mem_cmd, issue_valid, issue_pc); else n_pass++;
    tick;
    n_total++; if ({mem_cmd, issue_valid} !== {4'h0, 1'b0})
      $display("FAIL hold_idle got cmd=%h v=%b want 0/0", mem_cmd, issue_valid); else n_pass++;
    fetch_hold = 1'b0;
    tick;
    n_total++; if ({mem_cmd, mem_addr} !== {4'h1, 32'h804})
      $display("FAIL hold_resume got cmd=%h addr=%h want 1/804", mem_cmd, mem_addr); else n_pass++;
    tick;
    n_total++; if ({issue_valid, issue_pc} !== {1'b1, 32'h804})
      $display("FAIL hold_issue got v=%b pc=%h want 1/804", issue_valid, issue_pc); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_back_to_back;
    test_fifo_full;
    test_redirect_drain;
    test_bus_error;
    test_timeout;
    test_hold;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
